if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_pkg.sv | 7 +
 rtl/if_id_queue.sv | 75 +++++++
 tb/tb_if_id_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch/decode constants for the IF and ID stages
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF-to-ID fetch queue with flush, registered head, no bypass
module if_id_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = if_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    // Both handshakes look only at registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (cnt < CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = cnt;

    assign out_pc   = out_valid ? pc_mem[rd_ptr]   : XLEN'(NOP);
    assign out_inst = out_valid ? inst_mem[rd_ptr] : XLEN'(NOP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_ready;
    logic [1:0]      count;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] c, input logic ov,
                             input logic ir, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".count"},     64'(count),     64'(c));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(ir));
        chk({tag, ".out_pc"},    64'(out_pc),    64'(pc));
        chk({tag, ".out_inst"},  64'(out_inst),  64'(inst));
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;

        // reset
        step();
        chk_state("reset", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
        rst = 1'b1;

        // fill to full, push while full ignored
        in_valid = 1'b1; in_pc = 32'h00; in_inst = 32'h1111_1111;
        step();
        chk_state("fill1", 2'd1, 1'b1, 1'b1, 32'h00, 32'h1111_1111);
        in_pc = 32'h04; in_inst = 32'h2222_2222;
        step();
        chk_state("fill2", 2'd2, 1'b1, 1'b0, 32'h00, 32'h1111_1111);
        in_pc = 32'h08; in_inst = 32'h3333_3333;
        step();
        chk_state("full_hold", 2'd2, 1'b1, 1'b0, 32'h00, 32'h1111_1111);
        out_ready = 1'b1;
        step();
        chk_state("full_pop", 2'd1, 1'b1, 1'b1, 32'h04, 32'h2222_2222);
        in_valid = 1'b0;
        step();
        chk_state("drain", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        // streaming, pointers wrap many times
        in_valid = 1'b1; out_ready = 1'b1;
        in_pc = 32'h00; in_inst = 32'hA000_0000;
        step();
        chk_state("stream0", 2'd1, 1'b1, 1'b1, 32'h00, 32'hA000_0000);
        for (int i = 1; i < 16; i++) begin
            in_pc   = 32'(i * 4);
            in_inst = 32'hA000_0000 | 32'(i);
            step();
            chk("stream.count", 64'(count), 64'd1);
            chk("stream.out_pc", 64'(out_pc), 64'(i * 4));
            chk("stream.out_inst", 64'(out_inst), 64'(32'hA000_0000 | 32'(i)));
        end
        in_valid = 1'b0;
        step();
        chk_state("stream_end", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        // flush discards entries and same-cycle push
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h10; in_inst = 32'h5555_5555;
        step();
        in_pc = 32'h14; in_inst = 32'h6666_6666;
        step();
        chk("preflush.count", 64'(count), 64'd2);
        flush = 1'b1; out_ready = 1'b1;
        in_pc = 32'h40; in_inst = 32'h7777_7777;
        step();
        chk_state("flush", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
        flush = 1'b0; out_ready = 1'b0;
        in_pc = 32'h80; in_inst = 32'h8888_8888;
        step();
        chk_state("postflush", 2'd1, 1'b1, 1'b1, 32'h80, 32'h8888_8888);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk_state("postflush_pop", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        // pops on empty ignored
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty.count", 64'(count), 64'd0);
            chk("empty.out_valid", 64'(out_valid), 64'd0);
        end

        // reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h100; in_inst = 32'h9999_9999;
        step();
        chk("midrst_pre.count", 64'(count), 64'd1);
        out_ready = 1'b1; in_pc = 32'h104; in_inst = 32'hAAAA_AAAA;
        rst = 1'b0;
        step();
        chk_state("midrst", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk_state("midrst_after", 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
